// File: rtl/fifo_pkg.sv
// Shared FIFO read-side types: default widths and the packer FSM state encoding.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int PACK_N_DEF  = 4;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/pack_out_reg.sv
// Valid/ready output register for packed words; holds data and lane count stable under backpressure.
module pack_out_reg
    import fifo_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [OUT_W-1:0] i_data,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_slot_free
);

    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_cnt   <= i_cnt;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_cnt       = r_cnt;
    assign o_slot_free = !r_valid || i_ready;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the FIFO read port and packs PACK_N words into one output word, lane 0 in the LSBs.
// Optional PACK_FLUSH_EN adds a flush input that emits a partially filled word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W,
    parameter  int PACK_N = PACK_N_DEF,
    localparam int OUT_W  = DATA_W * PACK_N,
    localparam int CNT_W  = $clog2(PACK_N + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              fifo_rden,
    input  logic [DATA_W-1:0] fifo_rddata,
    input  logic              fifo_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic [CNT_W-1:0]  m_cnt
`ifdef PACK_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PACK_N);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_N - 1);
    localparam logic [CNT_W:0]   FULL_SUM  = (CNT_W + 1)'(PACK_N);

    pack_state_e      r_state;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;

    logic [OUT_W-1:0] w_acc_upd;
    logic [OUT_W-1:0] w_ld_data;
    logic [CNT_W-1:0] w_ld_cnt;
    logic [CNT_W:0]   w_inflight;
    logic             w_slot_free;
    logic             w_complete;
    logic             w_ld;
    logic             w_flush_act;
    logic             w_flush_emit;

    assign w_inflight = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_pend};
    assign w_complete = (r_state == ST_FILL) && r_pend && (r_cnt == LAST_LANE);

`ifdef PACK_FLUSH_EN
    logic r_flush;

    // A flush stays armed until the partial word leaves or the word completes on its own.
    assign w_flush_act  = (r_state == ST_FILL) && (r_flush || (flush && (w_inflight != '0)));
    assign w_flush_emit = w_flush_act && !r_pend && (r_cnt != '0) && w_slot_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_flush <= 1'b0;
        else       r_flush <= w_flush_act && !w_complete && !w_flush_emit;
    end
`else
    assign w_flush_act  = 1'b0;
    assign w_flush_emit = 1'b0;
`endif

    // A read may run one lane ahead of the output slot: it becomes lane 0 of the next word.
    assign fifo_rden = rstn && (r_state == ST_FILL) && !fifo_empty && !w_flush_act &&
                       ((w_inflight < FULL_SUM) ||
                        ((w_inflight == FULL_SUM) && r_pend && w_slot_free));

    always_comb begin
        w_acc_upd = r_acc;
        for (int i = 0; i < PACK_N; i++) begin
            if (r_pend && (r_cnt == CNT_W'(i))) w_acc_upd[i*DATA_W +: DATA_W] = fifo_rddata;
        end
    end

    always_comb begin
        w_ld      = 1'b0;
        w_ld_data = r_acc;
        w_ld_cnt  = FULL_CNT;
        if (r_state == ST_HOLD) begin
            w_ld = w_slot_free;
        end else if (w_complete) begin
            w_ld      = w_slot_free;
            w_ld_data = w_acc_upd;
        end else if (w_flush_emit) begin
            w_ld     = 1'b1;
            w_ld_cnt = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_FILL;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= fifo_rden;
            if (r_state == ST_HOLD) begin
                if (w_slot_free) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_FILL;
                end
            end else if (w_complete) begin
                if (w_slot_free) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc   <= w_acc_upd;
                    r_cnt   <= FULL_CNT;
                    r_state <= ST_HOLD;
                end
            end else if (w_flush_emit) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_pend) begin
                r_acc <= w_acc_upd;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    pack_out_reg #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_out (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_ld),
        .i_data      (w_ld_data),
        .i_cnt       (w_ld_cnt),
        .i_ready     (m_ready),
        .o_valid     (m_valid),
        .o_data      (m_data),
        .o_cnt       (m_cnt),
        .o_slot_free (w_slot_free)
    );

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Downstream read-side stage of the synchronous FIFO. It drains DATA_W-bit words from the FIFO read port whenever data is available and packs PACK_N consecutive words into one OUT_W-bit word. The packed word is presented on a valid/ready output stream. It is the FIFO's only reader and drives the FIFO's i_rden directly.

## Interface
Parameters:
- DATA_W, default 8: FIFO word width. Must match the FIFO instance.
- PACK_N, default 4: FIFO words per packed word; must be ≥2.
- OUT_W, localparam, DATA_W*PACK_N: packed word width.
- CNT_W, localparam, $clog2(PACK_N+1): lane-count width.

Ports (clock is clk; reset is rstn, asynchronous, active-low):
- clk  in  1  rising-edge clock, shared with the FIFO.
- rstn  in  1  asynchronous active-low reset.
- fifo_rden  out  1  drives FIFO i_rden.
- fifo_rddata  in  DATA_W  from FIFO o_rddata; valid the cycle after fifo_rden.
- fifo_empty  in  1  from FIFO o_empty (registered in the FIFO).
- m_valid  out  1  packed word available.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  OUT_W  packed word; lane 0 (first word read) sits in bits [DATA_W-1:0].
- m_cnt  out  CNT_W  number of valid lanes in m_data.
- flush  in  1  present only with PACK_FLUSH_EN.

## Operation
- FIFO read contract: fifo_rden is sampled at the edge. fifo_rddata is valid for exactly the following cycle. fifo_rden is never asserted while fifo_empty=1.
- State:
  - acc (OUT_W).
  - cnt: lanes captured, 0..PACK_N.
  - pend: a read is in flight, 1 bit.
  - FSM in FILL or HOLD.
  - Output register: m_data, m_cnt, m_valid.
- slot_free = !m_valid || m_ready.
- fifo_rden (combinational) is asserted in FILL when !fifo_empty and either:
  - cnt+pend < PACK_N, or
  - cnt+pend == PACK_N && pend && slot_free. The new read becomes lane 0 of the next word.
- Capture: when pend=1, fifo_rddata is written into lane cnt.
  - If this completes the word and slot_free: acc plus the new lane loads m_data at the same edge, m_valid=1, m_cnt=PACK_N, and cnt becomes 0 (or 1 if a read-ahead lane lands next).
  - If it completes the word and !slot_free: go to HOLD.
- HOLD: no reads. When slot_free, transfer acc to the output register, cnt=0, and return to FILL.
- m_valid falls after acceptance unless a new word loads at the same edge.
- While m_valid && !m_ready, m_data and m_cnt are held stable.
- Unused lanes of m_data are zero.

## Timing
- Reset values: fifo_rden=0, m_valid=0, m_data=0, m_cnt=0, cnt=0, pend=0, FSM=FILL.
- Latency: with a non-empty FIFO and m_ready=1:
  - first fifo_rden in cycle 0;
  - m_valid rises in cycle PACK_N+1.
- Throughput: one FIFO read per cycle sustained. One packed word every PACK_N cycles while m_ready=1.
- FIFO going empty mid-word: cnt holds and no output is produced. Reading resumes on the cycle fifo_empty falls.
- Backpressure: at most one completed word in acc plus one in the output register. fifo_rden stays low in HOLD.
- Reset asserted mid-operation: all state clears immediately. An in-flight read is discarded; the FIFO shares rstn.

## Configuration
- PACK_FLUSH_EN defined: flush port exists.
  - A flush pulse in FILL with cnt+pend>0 blocks new reads, waits for pend to clear, then emits the partial word with m_cnt = lanes captured and upper lanes zero.
  - A flush with cnt+pend=0 is ignored.
  - A flush while in HOLD is ignored.
- PACK_FLUSH_EN undefined: no flush port, and m_cnt is always PACK_N when m_valid=1.

## Structure
- fifo_pkg: DATA_W, the default PACK_N, and the state enum (FILL, HOLD).
- One sub-module, pack_out_reg: the valid/ready output register holding m_data and m_cnt, with the load/hold logic. The FSM and accumulator stay in fifo_rd_packer.

## Test plan
- PACK_N=4, FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 → m_data=0x44332211, m_cnt=4, m_valid for 1 cycle, in cycle 5.
- 16 words 0x00..0x0F streamed, m_ready=1 → four outputs on consecutive 4-cycle boundaries with no bubble (0x03020100 … 0x0F0E0D0C) and fifo_rden continuously high.
- m_ready=0 with 12 words queued → first word held stable, acc fills, HOLD, fifo_rden=0. Four words remain in the FIFO. Releasing m_ready drains them in order.
- FIFO empties after 2 words → no m_valid. Push 2 more → m_data=0xWWZZYYXX in correct lane order.
- rstn pulsed low with pend=1 and m_valid=1 → all outputs 0 asynchronously. Next packed word starts at lane 0.
- (PACK_FLUSH_EN) 3 words 0xA1,0xB2,0xC3, then flush → m_data=0x00C3B2A1, m_cnt=3. A second flush with an empty acc produces no output.
